// File: rtl/sid_bus_sched.sv
// sid_bus_sched: SID bus clock generator and two-port access scheduler.
// Each granted access becomes one phi2-aligned chip-select strobe over cnt CS_START..31.
module sid_bus_sched #(
  parameter bit          RR       = 1'b0,
  parameter int unsigned CS_START = 20
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic       p0_valid,
  input  logic       p0_we,
  input  logic [4:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic       p0_ready,
  output logic       p0_resp,
  input  logic       p1_valid,
  input  logic       p1_we,
  input  logic [4:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic       p1_ready,
  output logic       p1_resp,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       sid_clk,
  output logic [4:0] sid_a,
  output logic [7:0] sid_d_out,
  output logic       sid_d_oe,
  input  logic [7:0] sid_d_in,
  output logic       sid_cs,
  output logic       sid_wr
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
  localparam logic [4:0] CS_PRE = 5'(CS_START - 1);
  state_t      state_q;
  logic [4:0]  cnt_q, a_q, sel_addr;
  logic [7:0]  d_out_q, rdata_q, sel_wdata;
  logic [1:0]  ready_q, resp_q;
  logic        cs_q, wr_q, oe_q, busy_q, last_q, owner_q;
  logic        grant1, accept, sel_we;
  // last_q = 1 means port 1 was served last, so a tie under RR goes to port 0
  assign grant1    = p1_valid & (~p0_valid | (RR & ~last_q));
  assign accept    = (state_q == IDLE) & (p0_valid | p1_valid) & ~|resp_q;
  assign sel_we    = grant1 ? p1_we : p0_we;
  assign sel_addr  = grant1 ? p1_addr : p0_addr;
  assign sel_wdata = grant1 ? p1_wdata : p0_wdata;
  always_ff @(posedge clk32) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      d_out_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      resp_q  <= '0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 5'd1;
      ready_q <= '0;
      resp_q  <= '0;
      case (state_q)
        IDLE: begin
          busy_q <= accept;
          if (accept) begin
            ready_q <= grant1 ? 2'b10 : 2'b01;
            owner_q <= grant1;
            last_q  <= grant1;
            a_q     <= sel_addr;
            wr_q    <= ~sel_we;
            d_out_q <= sel_wdata;
            oe_q    <= sel_we;
            state_q <= SETUP;
          end
        end
        SETUP: if (cnt_q == CS_PRE) begin
          cs_q    <= 1'b0;
          state_q <= STROBE;
        end
        STROBE: if (cnt_q == 5'd31) begin
          rdata_q <= wr_q ? sid_d_in : rdata_q;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          oe_q    <= 1'b0;
          resp_q  <= owner_q ? 2'b10 : 2'b01;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign p0_ready  = ready_q[0];
  assign p1_ready  = ready_q[1];
  assign p0_resp   = resp_q[0];
  assign p1_resp   = resp_q[1];
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sid_clk   = cnt_q[4];
  assign sid_a     = a_q;
  assign sid_d_out = d_out_q;
  assign sid_d_oe  = oe_q;
  assign sid_cs    = cs_q;
  assign sid_wr    = wr_q;
endmodule
